run_sequencer: RTL and testbench

RUN_SEQUENCER -- requirements
Module: run_sequencer

---
 rtl/run_seq_pkg.sv | 27 ++
 rtl/sat_counter.sv | 23 ++
 rtl/run_sequencer.sv | 128 ++++++++++++
 tb/tb_run_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/run_seq_pkg.sv
// rtl/run_seq_pkg.sv - state encoding, default parameters and release-edge helper for run_sequencer
package run_seq_pkg;

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_RELEASE = 3'd1,
    ST_RUN     = 3'd2,
    ST_DONE    = 3'd3,
    ST_TIMEOUT = 3'd4
  } run_state_t;

  localparam int DEF_NUM_DOMAINS    = 2;
  localparam int DEF_RST_CYCLES     = 25;
  localparam int DEF_STAGGER        = 0;
  localparam int DEF_TIMEOUT_CYCLES = 150000;
  localparam int DEF_CNT_W          = 32;

  // Width of the post-reset edge counter; wide enough for any sane release schedule.
  localparam int EDGE_W = 32;

  // Edge number (1-based after rst_in falls) on which domain idx leaves reset.
  function automatic logic [EDGE_W-1:0] release_edge(input int rst_cycles, input int stagger,
                                                     input int idx);
    return EDGE_W'(rst_cycles + idx * stagger);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - enable-gated up counter that holds at all-ones
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         at_max
);

  assign at_max = &count;

  // Advance on enabled cycles, sticking at the maximum instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en && !at_max) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/run_sequencer.sv
// rtl/run_sequencer.sv - staggered multi-domain reset release, run-phase cycle counter and watchdog (SIM_FINISH_EN adds a simulation stop)
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int NUM_DOMAINS    = DEF_NUM_DOMAINS,
  parameter int RST_CYCLES     = DEF_RST_CYCLES,
  parameter int STAGGER        = DEF_STAGGER,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   pause_in,
  input  logic                   halt_in,
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic                   running_o,
  output logic                   done_o,
  output logic                   timeout_o,
  output logic [CNT_W-1:0]       cycle_cnt_o
);

  localparam logic [EDGE_W-1:0] FIRST_EDGE    = release_edge(RST_CYCLES, STAGGER, 0);
  localparam logic [EDGE_W-1:0] LAST_EDGE     = release_edge(RST_CYCLES, STAGGER, NUM_DOMAINS - 1);
  localparam logic [63:0]       TIMEOUT_LIMIT = 64'(TIMEOUT_CYCLES);

  run_state_t        state;
  run_state_t        state_nxt;
  logic [EDGE_W-1:0] edge_cnt;
  logic [EDGE_W-1:0] edge_nxt;
  logic              seq_phase;
  logic              cnt_en;
  logic              at_max;
  logic              wd_hit;

  // The edge counter only matters while domains are still being released.
  assign seq_phase = (state == ST_HOLD) || (state == ST_RELEASE);
  assign edge_nxt  = edge_cnt + EDGE_W'(1);

  // Watchdog fires on the edge whose increment would land exactly on the limit;
  // a saturated counter can never advance, so it cannot reach a limit beyond its range.
  assign wd_hit = (TIMEOUT_CYCLES != 0) && !at_max &&
                  ((64'(cycle_cnt_o) + 64'd1) == TIMEOUT_LIMIT);

  // State register and post-reset edge counter.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= ST_HOLD;
      edge_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (seq_phase) begin
        edge_cnt <= edge_nxt;
      end
    end
  end

  // Drop each domain's reset on its scheduled edge; once low it stays low until rst_in.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rst_out <= '1;
    end else if (seq_phase) begin
      for (int i = 0; i < NUM_DOMAINS; i++) begin
        if (edge_nxt >= release_edge(RST_CYCLES, STAGGER, i)) begin
          rst_out[i] <= 1'b0;
        end
      end
    end
  end

  // Next-state and run-counter enable; halt outranks both pause and the watchdog.
  always_comb begin
    state_nxt = state;
    cnt_en    = 1'b0;
    case (state)
      ST_HOLD: begin
        if (edge_nxt == FIRST_EDGE) begin
          state_nxt = (FIRST_EDGE == LAST_EDGE) ? ST_RUN : ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (edge_nxt == LAST_EDGE) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (halt_in) begin
          state_nxt = ST_DONE;
        end else if (!pause_in) begin
          cnt_en = 1'b1;
          if (wd_hit) begin
            state_nxt = ST_TIMEOUT;
          end
        end
      end
      ST_DONE:    state_nxt = ST_DONE;
      ST_TIMEOUT: state_nxt = ST_TIMEOUT;
      default:    state_nxt = ST_HOLD;
    endcase
  end

  sat_counter #(
    .W(CNT_W)
  ) u_run_cnt (
    .clk   (clk_in),
    .rst   (rst_in),
    .en    (cnt_en),
    .count (cycle_cnt_o),
    .at_max(at_max)
  );

  // Terminal states are held until rst_in, so the flags follow the state directly.
  assign running_o = (state == ST_RUN);
  assign done_o    = (state == ST_DONE);
  assign timeout_o = (state == ST_TIMEOUT);

`ifdef SIM_FINISH_EN
  // Stop the simulation one edge after reaching a terminal state.
  always @(posedge clk_in) begin
    if (!rst_in && ((state == ST_DONE) || (state == ST_TIMEOUT))) begin
      $display("run_sequencer: state=%s cycle_cnt=%0d", state.name(), cycle_cnt_o);
      $finish;
    end
  end
`else
  // Completion is reported only through done_o and timeout_o.
`endif

endmodule

// File: tb/tb_run_sequencer.sv
// tb/tb_run_sequencer.sv - directed scoreboard bench for run_sequencer
module tb_run_sequencer;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic        rst_a, pause_a, halt_a;
  logic [2:0]  rst_out_a;
  logic        running_a, done_a, timeout_a;
  logic [31:0] cnt_a;

  logic        rst_b, pause_b, halt_b;
  logic [1:0]  rst_out_b;
  logic        running_b, done_b, timeout_b;
  logic [3:0]  cnt_b;

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    string tag;
    int    bit_id;
    int    edge_n;
  } sb_t;

  sb_t sb_q[$];

  run_sequencer #(
    .NUM_DOMAINS(3), .RST_CYCLES(25), .STAGGER(2), .TIMEOUT_CYCLES(100), .CNT_W(32)
  ) dut_a (
    .clk_in(clk_in), .rst_in(rst_a), .pause_in(pause_a), .halt_in(halt_a),
    .rst_out(rst_out_a), .running_o(running_a), .done_o(done_a),
    .timeout_o(timeout_a), .cycle_cnt_o(cnt_a)
  );

  run_sequencer #(
    .NUM_DOMAINS(2), .RST_CYCLES(4), .STAGGER(0), .TIMEOUT_CYCLES(0), .CNT_W(4)
  ) dut_b (
    .clk_in(clk_in), .rst_in(rst_b), .pause_in(pause_b), .halt_in(halt_b),
    .rst_out(rst_out_b), .running_o(running_b), .done_o(done_b),
    .timeout_o(timeout_b), .cycle_cnt_o(cnt_b)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_event(input int bit_id, input int e);
    sb_t it;
    if (sb_q.size() == 0) begin
      check("sb_unexpected_event", 64'(bit_id), 64'd99);
      return;
    end
    it = sb_q.pop_front();
    check({it.tag, "_bit"}, 64'(bit_id), 64'(it.bit_id));
    check({it.tag, "_edge"}, 64'(e), 64'(it.edge_n));
  endtask

  task automatic sb_drain();
    sb_t it;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      check({it.tag, "_missing"}, 64'hFFFF, 64'(it.edge_n));
    end
  endtask

  // Release rst_a and watch the staggered domain releases and the RUN entry.
  task automatic seq_a();
    logic [2:0] prev;
    logic       prev_run;
    sb_q.push_back('{"rst0_fall", 0, 25});
    sb_q.push_back('{"rst1_fall", 1, 27});
    sb_q.push_back('{"rst2_fall", 2, 29});
    sb_q.push_back('{"run_rise", 3, 29});
    rst_a = 1'b0;
    check("a_hold_rst_out", 64'(rst_out_a), 64'd7);
    prev     = rst_out_a;
    prev_run = running_a;
    for (int e = 1; e <= 60 && sb_q.size() > 0; e++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        if (prev[i] && !rst_out_a[i]) sb_event(i, e);
      end
      if (!prev_run && running_a) sb_event(3, e);
      prev     = rst_out_a;
      prev_run = running_a;
    end
    sb_drain();
    check("a_run_rst_out", 64'(rst_out_a), 64'd0);
    check("a_run_cnt0", 64'(cnt_a), 64'd0);
  endtask

  task automatic run_until_a(input int target, input int budget);
    int k = 0;
    while (cnt_a != 32'(target) && k < budget) begin
      tick();
      k++;
    end
    check("a_reach_cnt", 64'(cnt_a), 64'(target));
  endtask

  task automatic wait_timeout_a(input int n_start, input int exp_n);
    sb_t it;
    int  n = n_start;
    sb_q.push_back('{"timeout_edge", 4, exp_n});
    while (!timeout_a && n < 400) begin
      tick();
      n++;
    end
    it = sb_q.pop_front();
    check(it.tag, timeout_a ? 64'(n) : 64'hFFFF, 64'(it.edge_n));
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit: bench did not reach its end");
    $fatal(1, "time limit");
  end

  initial begin
    int e_run;
    rst_a = 1'b1; pause_a = 1'b0; halt_a = 1'b0;
    rst_b = 1'b1; pause_b = 1'b0; halt_b = 1'b0;
    repeat (3) tick();

    check("rst_rst_out", 64'(rst_out_a), 64'd7);
    check("rst_running", 64'(running_a), 64'd0);
    check("rst_done", 64'(done_a), 64'd0);
    check("rst_timeout", 64'(timeout_a), 64'd0);
    check("rst_cnt", 64'(cnt_a), 64'd0);
    check("rst_b_rst_out", 64'(rst_out_b), 64'd3);

    // Halt at run cycle 40.
    seq_a();
    run_until_a(40, 200);
    halt_a = 1'b1;
    tick();
    halt_a = 1'b0;
    check("halt_done", 64'(done_a), 64'd1);
    check("halt_timeout", 64'(timeout_a), 64'd0);
    check("halt_cnt", 64'(cnt_a), 64'd40);
    check("halt_running", 64'(running_a), 64'd0);
    repeat (5) tick();
    check("halt_cnt_frozen", 64'(cnt_a), 64'd40);
    check("halt_done_sticky", 64'(done_a), 64'd1);
    check("halt_rst_out_low", 64'(rst_out_a), 64'd0);

    // Reset reasserted mid-RUN at cycle 50, then full resequence.
    rst_a = 1'b1;
    tick();
    seq_a();
    run_until_a(50, 200);
    rst_a = 1'b1;
    #2;
    check("midrst_rst_out", 64'(rst_out_a), 64'd7);
    check("midrst_cnt", 64'(cnt_a), 64'd0);
    check("midrst_running", 64'(running_a), 64'd0);
    tick();
    seq_a();

    // Watchdog with no halt.
    wait_timeout_a(0, 100);
    check("wd_cnt", 64'(cnt_a), 64'd100);
    check("wd_done", 64'(done_a), 64'd0);
    repeat (3) tick();
    check("wd_cnt_frozen", 64'(cnt_a), 64'd100);
    check("wd_sticky", 64'(timeout_a), 64'd1);

    // Watchdog delayed by 10 paused cycles.
    rst_a = 1'b1;
    tick();
    seq_a();
    repeat (20) tick();
    pause_a = 1'b1;
    repeat (10) tick();
    pause_a = 1'b0;
    check("pause_cnt_held", 64'(cnt_a), 64'd20);
    wait_timeout_a(30, 110);
    check("pause_wd_cnt", 64'(cnt_a), 64'd100);

    // Halt on the same edge the watchdog would expire.
    rst_a = 1'b1;
    tick();
    seq_a();
    run_until_a(99, 200);
    halt_a = 1'b1;
    tick();
    halt_a = 1'b0;
    check("coinc_done", 64'(done_a), 64'd1);
    check("coinc_timeout", 64'(timeout_a), 64'd0);

    // Narrow counter saturation, no watchdog; pause/halt ignored during HOLD.
    halt_b  = 1'b1;
    pause_b = 1'b1;
    rst_b   = 1'b0;
    e_run   = -1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (running_b) begin
        e_run = e;
        break;
      end
    end
    halt_b  = 1'b0;
    pause_b = 1'b0;
    check("b_run_edge", 64'(e_run), 64'd4);
    check("b_rst_out", 64'(rst_out_b), 64'd0);
    check("b_hold_ignores_halt", 64'(done_b), 64'd0);
    repeat (10) tick();
    check("b_cnt10", 64'(cnt_b), 64'd10);
    repeat (10) tick();
    check("b_cnt_sat", 64'(cnt_b), 64'd15);
    check("b_no_timeout", 64'(timeout_b), 64'd0);
    check("b_still_running", 64'(running_b), 64'd1);
    pause_b = 1'b1;
    halt_b  = 1'b1;
    tick();
    check("b_halt_while_paused", 64'(done_b), 64'd1);
    check("b_cnt_final", 64'(cnt_b), 64'd15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
